// File: rtl/fu_branch_simt_if.sv
// Branch-kind encoding and the issue/result bundle of fu_branch_simt.
// Defining BRANCH_PRED_EN adds the pred_taken / mispredict signals.
package isa_pkg;
  typedef enum logic [2:0] {
    BT_BEQ  = 3'd0,
    BT_BNE  = 3'd1,
    BT_BLT  = 3'd2,
    BT_BGE  = 3'd3,
    BT_BLTU = 3'd4,
    BT_BGEU = 3'd5
  } branch_t;
endpackage

interface fu_branch_simt_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LANES  = 4
);
  import isa_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic                    branch;
  logic [1:0]              j_type;
  branch_t                 branch_type;
  logic [LANES-1:0]        lane_mask;
  logic [LANES*DATA_W-1:0] reg_a;
  logic [LANES*DATA_W-1:0] reg_b;
  logic [DATA_W-1:0]       imm;
  logic [ADDR_W-1:0]       current_pc;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        taken_mask;
  logic                    diverged;
  logic [ADDR_W-1:0]       next_pc;
  logic [ADDR_W-1:0]       target_pc;
  logic [ADDR_W-1:0]       link_addr;
`ifdef BRANCH_PRED_EN
  logic                    pred_taken;
  logic                    mispredict;
`endif

  // Issue side / fetch side
  modport master (
    output in_valid, branch, j_type, branch_type, lane_mask, reg_a, reg_b, imm, current_pc,
    output out_ready,
    input  in_ready, out_valid, taken_mask, diverged, next_pc, target_pc, link_addr
`ifdef BRANCH_PRED_EN
    , output pred_taken
    , input  mispredict
`endif
  );

  // Branch unit side
  modport slave (
    input  in_valid, branch, j_type, branch_type, lane_mask, reg_a, reg_b, imm, current_pc,
    input  out_ready,
    output in_ready, out_valid, taken_mask, diverged, next_pc, target_pc, link_addr
`ifdef BRANCH_PRED_EN
    , input  pred_taken
    , output mispredict
`endif
  );
endinterface

// File: rtl/fu_branch_simt.sv
// Two-stage SIMT branch resolver: S1 registers per-lane compares, S2 holds the resolved result.
// Define BRANCH_PRED_EN to capture pred_taken with each instruction and report mispredict.
module fu_branch_simt
  import isa_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LANES  = 4
) (
  input logic             CLK,
  input logic             nRST,
  fu_branch_simt_if.slave bus
);
  logic s2_free, in_ready, accept;

  // S1 payload
  logic              s1_valid_q, s1_valid_d;
  logic [LANES-1:0]  cmp_q, cmp_d, mask_q, mask_d, lane_cmp;
  logic              branch_q, branch_d;
  logic [1:0]        j_type_q, j_type_d;
  logic [ADDR_W-1:0] pc_q, pc_d, imm_q, imm_d, base_q, base_d;
  logic [DATA_W-1:0] base_sel;
  logic [ADDR_W-1:0] imm_ext, base_ext;

  // S2 result
  logic              out_valid_q, out_valid_d, diverged_q, diverged_d;
  logic [LANES-1:0]  taken_q, taken_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d, target_q, target_d, link_q, link_d;

  logic [LANES-1:0]  res_taken;
  logic [ADDR_W-1:0] res_target, res_next, pc_plus4, jalr_sum;
  logic              res_div;

`ifdef BRANCH_PRED_EN
  logic pred_q, pred_d, misp_q, misp_d;
`endif

  assign s2_free      = !out_valid_q || bus.out_ready;
  assign in_ready     = !s1_valid_q || s2_free;
  assign accept       = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;

  always_comb begin
    logic [DATA_W-1:0] op_a, op_b;
    op_a     = '0;
    op_b     = '0;
    lane_cmp = '0;
    for (int i = 0; i < LANES; i++) begin
      op_a = bus.reg_a[i*DATA_W +: DATA_W];
      op_b = bus.reg_b[i*DATA_W +: DATA_W];
      case (bus.branch_type)
        BT_BEQ:  lane_cmp[i] = (op_a == op_b);
        BT_BNE:  lane_cmp[i] = (op_a != op_b);
        BT_BLT:  lane_cmp[i] = ($signed(op_a) < $signed(op_b));
        BT_BGE:  lane_cmp[i] = ($signed(op_a) >= $signed(op_b));
        BT_BLTU: lane_cmp[i] = (op_a < op_b);
        BT_BGEU: lane_cmp[i] = (op_a >= op_b);
        default: lane_cmp[i] = 1'b0;
      endcase
    end
    // JALR base comes from the lowest active lane; an empty mask falls back to lane 0.
    base_sel = bus.reg_a[DATA_W-1:0];
    for (int i = LANES - 1; i >= 0; i--) begin
      if (bus.lane_mask[i]) base_sel = bus.reg_a[i*DATA_W +: DATA_W];
    end
  end

  if (ADDR_W <= DATA_W) begin : g_trunc
    assign imm_ext  = bus.imm[ADDR_W-1:0];
    assign base_ext = base_sel[ADDR_W-1:0];
  end else begin : g_sext
    assign imm_ext  = {{(ADDR_W-DATA_W){bus.imm[DATA_W-1]}}, bus.imm};
    assign base_ext = {{(ADDR_W-DATA_W){base_sel[DATA_W-1]}}, base_sel};
  end

  always_comb begin
    s1_valid_d = s2_free ? 1'b0 : s1_valid_q;
    cmp_d      = cmp_q;
    mask_d     = mask_q;
    branch_d   = branch_q;
    j_type_d   = j_type_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    base_d     = base_q;
`ifdef BRANCH_PRED_EN
    pred_d     = pred_q;
`endif
    if (accept) begin
      s1_valid_d = 1'b1;
      cmp_d      = lane_cmp & bus.lane_mask;
      mask_d     = bus.lane_mask;
      branch_d   = bus.branch;
      j_type_d   = bus.j_type;
      pc_d       = bus.current_pc;
      imm_d      = imm_ext;
      base_d     = base_ext;
`ifdef BRANCH_PRED_EN
      pred_d     = bus.pred_taken;
`endif
    end
  end

  always_comb begin
    pc_plus4   = pc_q + ADDR_W'(4);
    jalr_sum   = base_q + imm_q;
    res_taken  = '0;
    res_target = pc_plus4;
    case (j_type_q)
      2'd1: begin
        res_taken  = mask_q;
        res_target = pc_q + imm_q;
      end
      2'd2: begin
        res_taken  = mask_q;
        res_target = {jalr_sum[ADDR_W-1:1], 1'b0};
      end
      default: begin
        if (branch_q) begin
          res_taken  = cmp_q;
          res_target = pc_q + imm_q;
        end
      end
    endcase
    res_div  = (res_taken != '0) && (res_taken != mask_q);
    // Divergent or empty-mask instructions fall through; reconvergence logic uses target_pc.
    res_next = ((res_taken == mask_q) && (mask_q != '0)) ? res_target : pc_plus4;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    taken_d     = taken_q;
    diverged_d  = diverged_q;
    next_pc_d   = next_pc_q;
    target_d    = target_q;
    link_d      = link_q;
`ifdef BRANCH_PRED_EN
    misp_d      = misp_q;
`endif
    if (s2_free) begin
      out_valid_d = s1_valid_q;
`ifdef BRANCH_PRED_EN
      misp_d      = s1_valid_q &&
                    (pred_q != ((res_next == res_target) && (res_taken != '0)));
`endif
      if (s1_valid_q) begin
        taken_d    = res_taken;
        diverged_d = res_div;
        next_pc_d  = res_next;
        target_d   = res_target;
        link_d     = pc_plus4;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q  <= 1'b0;
      cmp_q       <= '0;
      mask_q      <= '0;
      branch_q    <= 1'b0;
      j_type_q    <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      base_q      <= '0;
      out_valid_q <= 1'b0;
      taken_q     <= '0;
      diverged_q  <= 1'b0;
      next_pc_q   <= '0;
      target_q    <= '0;
      link_q      <= '0;
`ifdef BRANCH_PRED_EN
      pred_q      <= 1'b0;
      misp_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      cmp_q       <= cmp_d;
      mask_q      <= mask_d;
      branch_q    <= branch_d;
      j_type_q    <= j_type_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      base_q      <= base_d;
      out_valid_q <= out_valid_d;
      taken_q     <= taken_d;
      diverged_q  <= diverged_d;
      next_pc_q   <= next_pc_d;
      target_q    <= target_d;
      link_q      <= link_d;
`ifdef BRANCH_PRED_EN
      pred_q      <= pred_d;
      misp_q      <= misp_d;
`endif
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.taken_mask = taken_q;
  assign bus.diverged   = diverged_q;
  assign bus.next_pc    = next_pc_q;
  assign bus.target_pc  = target_q;
  assign bus.link_addr  = link_q;
`ifdef BRANCH_PRED_EN
  assign bus.mispredict = misp_q;
`endif
endmodule

// File: tb/tb_fu_branch_simt.sv
// Directed bench for fu_branch_simt (LANES=4): compares, jumps, back-pressure and reset.
// Prediction checks run only when BRANCH_PRED_EN is defined.
module tb_fu_branch_simt;
  import isa_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int checks = 0;
  int failures = 0;

  fu_branch_simt_if #(.DATA_W(32), .ADDR_W(32), .LANES(4)) bus ();

  fu_branch_simt #(.DATA_W(32), .ADDR_W(32), .LANES(4)) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [127:0] pack4(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic br, input logic [1:0] jt, input branch_t bt,
                       input logic [3:0] m, input logic [127:0] a, b,
                       input logic [31:0] im, pc);
    bus.branch      = br;
    bus.j_type      = jt;
    bus.branch_type = bt;
    bus.lane_mask   = m;
    bus.reg_a       = a;
    bus.reg_b       = b;
    bus.imm         = im;
    bus.current_pc  = pc;
    bus.in_valid    = 1'b1;
  endtask

  // Holds in_valid until the unit takes the instruction (bounded), then drops it.
  task automatic accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.in_ready) ok = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%h want=0", bus.out_valid); end
    checks++; if (bus.taken_mask !== 4'h0) begin failures++; $display("FAIL rst_taken got=%h want=0", bus.taken_mask); end
    checks++; if (bus.diverged !== 1'b0) begin failures++; $display("FAIL rst_diverged got=%h want=0", bus.diverged); end
    checks++; if (bus.next_pc !== 32'h0) begin failures++; $display("FAIL rst_next_pc got=%h want=0", bus.next_pc); end
    checks++; if (bus.target_pc !== 32'h0) begin failures++; $display("FAIL rst_target got=%h want=0", bus.target_pc); end
    checks++; if (bus.link_addr !== 32'h0) begin failures++; $display("FAIL rst_link got=%h want=0", bus.link_addr); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%h want=1", bus.in_ready); end
`ifdef BRANCH_PRED_EN
    checks++; if (bus.mispredict !== 1'b0) begin failures++; $display("FAIL rst_mispredict got=%h want=0", bus.mispredict); end
`endif
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_beq();
    bit ok;
    drive(1'b1, 2'd0, BT_BEQ, 4'hF, pack4(10, 10, 10, 10), pack4(10, 10, 10, 10), 32'd100, 32'd0);
    accept(ok);
    checks++; if (!ok) begin failures++; $display("FAIL beq_accept got=timeout want=accept"); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL beq_early_valid got=%h want=0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL beq_valid got=%h want=1", bus.out_valid); end
    checks++; if (bus.taken_mask !== 4'hF) begin failures++; $display("FAIL beq_taken got=%h want=f", bus.taken_mask); end
    checks++; if (bus.diverged !== 1'b0) begin failures++; $display("FAIL beq_diverged got=%h want=0", bus.diverged); end
    checks++; if (bus.next_pc !== 32'd100) begin failures++; $display("FAIL beq_next_pc got=%0d want=100", bus.next_pc); end
    checks++; if (bus.link_addr !== 32'd4) begin failures++; $display("FAIL beq_link got=%0d want=4", bus.link_addr); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL beq_drain got=%h want=0", bus.out_valid); end
  endtask

  task automatic test_bltu();
    bit ok;
    drive(1'b1, 2'd0, BT_BLTU, 4'hF, pack4(8, 10, 8, 32'h8000_0000),
          pack4(10, 8, 32'h8000_0000, 8), 32'd100, 32'd16);
    accept(ok);
    tick();
    checks++; if (!ok || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bltu_valid got=%h want=1", bus.out_valid); end
    checks++; if (bus.taken_mask !== 4'b0101) begin failures++; $display("FAIL bltu_taken got=%b want=0101", bus.taken_mask); end
    checks++; if (bus.diverged !== 1'b1) begin failures++; $display("FAIL bltu_diverged got=%h want=1", bus.diverged); end
    checks++; if (bus.next_pc !== 32'd20) begin failures++; $display("FAIL bltu_next_pc got=%0d want=20", bus.next_pc); end
    checks++; if (bus.target_pc !== 32'd116) begin failures++; $display("FAIL bltu_target got=%0d want=116", bus.target_pc); end
    tick();
  endtask

  task automatic test_jalr();
    bit ok;
    drive(1'b0, 2'd2, BT_BEQ, 4'b0110, pack4(32'h555, 32'h21, 32'h1000, 32'h2000),
          pack4(0, 0, 0, 0), 32'h100, 32'd76);
    accept(ok);
    tick();
    checks++; if (!ok || bus.out_valid !== 1'b1) begin failures++; $display("FAIL jalr_valid got=%h want=1", bus.out_valid); end
    checks++; if (bus.target_pc !== 32'h120) begin failures++; $display("FAIL jalr_target got=%h want=120", bus.target_pc); end
    checks++; if (bus.next_pc !== 32'h120) begin failures++; $display("FAIL jalr_next_pc got=%h want=120", bus.next_pc); end
    checks++; if (bus.link_addr !== 32'd80) begin failures++; $display("FAIL jalr_link got=%0d want=80", bus.link_addr); end
    checks++; if (bus.taken_mask !== 4'b0110) begin failures++; $display("FAIL jalr_taken got=%b want=0110", bus.taken_mask); end
    tick();
  endtask

  task automatic test_jump_precedence();
    bit ok;
    // JAL overrides a not-taken BNE; negative imm
    drive(1'b1, 2'd1, BT_BNE, 4'b0011, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1),
          32'hFFFF_FFF8, 32'h40);
    accept(ok);
    tick();
    checks++; if (bus.taken_mask !== 4'b0011) begin failures++; $display("FAIL jal_taken got=%b want=0011", bus.taken_mask); end
    checks++; if (bus.next_pc !== 32'h38) begin failures++; $display("FAIL jal_next_pc got=%h want=38", bus.next_pc); end
    checks++; if (bus.link_addr !== 32'h44) begin failures++; $display("FAIL jal_link got=%h want=44", bus.link_addr); end
    // Reserved j_type acts as none, so branch decides
    drive(1'b1, 2'd3, BT_BEQ, 4'hF, pack4(3, 3, 3, 3), pack4(3, 3, 3, 3), 32'h10, 32'h80);
    accept(ok);
    tick();
    checks++; if (bus.taken_mask !== 4'hF) begin failures++; $display("FAIL jrsv_taken got=%h want=f", bus.taken_mask); end
    checks++; if (bus.next_pc !== 32'h90) begin failures++; $display("FAIL jrsv_next_pc got=%h want=90", bus.next_pc); end
    // Neither branch nor jump
    drive(1'b0, 2'd0, BT_BEQ, 4'hF, pack4(3, 3, 3, 3), pack4(3, 3, 3, 3), 32'h10, 32'h80);
    accept(ok);
    tick();
    checks++; if (bus.taken_mask !== 4'h0) begin failures++; $display("FAIL none_taken got=%h want=0", bus.taken_mask); end
    checks++; if (bus.target_pc !== 32'h84) begin failures++; $display("FAIL none_target got=%h want=84", bus.target_pc); end
    tick();
  endtask

  task automatic test_lane_mask_zero();
    bit ok;
    drive(1'b1, 2'd0, BT_BEQ, 4'h0, pack4(7, 7, 7, 7), pack4(7, 7, 7, 7), 32'd100, 32'hFFFF_FFFC);
    accept(ok);
    tick();
    checks++; if (!ok || bus.out_valid !== 1'b1) begin failures++; $display("FAIL m0_valid got=%h want=1", bus.out_valid); end
    checks++; if (bus.taken_mask !== 4'h0) begin failures++; $display("FAIL m0_taken got=%h want=0", bus.taken_mask); end
    checks++; if (bus.diverged !== 1'b0) begin failures++; $display("FAIL m0_diverged got=%h want=0", bus.diverged); end
    checks++; if (bus.next_pc !== 32'h0) begin failures++; $display("FAIL m0_next_pc got=%h want=0", bus.next_pc); end
    checks++; if (bus.target_pc !== 32'h60) begin failures++; $display("FAIL m0_target got=%h want=60", bus.target_pc); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd0, BT_BNE, 4'hF, pack4(1, 2, 3, 4), pack4(0, 0, 0, 0), 32'd8, 32'd200);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy0 got=%h want=1", bus.in_ready); end
    tick();
    drive(1'b1, 2'd0, BT_BNE, 4'hF, pack4(5, 5, 5, 5), pack4(5, 5, 5, 5), 32'd8, 32'd300);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy1 got=%h want=1", bus.in_ready); end
    tick();
    drive(1'b1, 2'd0, BT_BNE, 4'hF, pack4(1, 1, 5, 5), pack4(1, 2, 5, 6), 32'd8, 32'd400);
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_rdy c=%0d got=%h want=0", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.next_pc !== 32'd208 || bus.taken_mask !== 4'hF) begin
        failures++; $display("FAIL b2b_hold c=%0d got=%h/%0d/%h want=1/208/f", c, bus.out_valid, bus.next_pc, bus.taken_mask);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_release_rdy got=%h want=1", bus.in_ready); end
    checks++; if (bus.next_pc !== 32'd208) begin failures++; $display("FAIL b2b_out0 got=%0d want=208", bus.next_pc); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.next_pc !== 32'd304 || bus.taken_mask !== 4'h0) begin
      failures++; $display("FAIL b2b_out1 got=%h/%0d/%h want=1/304/0", bus.out_valid, bus.next_pc, bus.taken_mask);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.next_pc !== 32'd404 || bus.taken_mask !== 4'b1010
                  || bus.diverged !== 1'b1 || bus.target_pc !== 32'd408) begin
      failures++; $display("FAIL b2b_out2 got=%h/%0d/%b/%h/%0d want=1/404/1010/1/408", bus.out_valid,
                           bus.next_pc, bus.taken_mask, bus.diverged, bus.target_pc);
    end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%h want=0", bus.out_valid); end
  endtask

  task automatic test_reset_in_flight();
    bit ok;
    bus.out_ready = 1'b0;
    drive(1'b1, 2'd0, BT_BEQ, 4'hF, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 32'd64, 32'd0);
    accept(ok);
    drive(1'b1, 2'd0, BT_BEQ, 4'hF, pack4(2, 2, 2, 2), pack4(2, 2, 2, 2), 32'd64, 32'd8);
    accept(ok);
    checks++; if (!ok || bus.out_valid !== 1'b1) begin failures++; $display("FAIL rif_loaded got=%h want=1", bus.out_valid); end
    #2 nrst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rif_async got=%h want=0", bus.out_valid); end
    tick();
    nrst = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rif_stale c=%0d got=%h want=0", c, bus.out_valid); end
    end
  endtask

`ifdef BRANCH_PRED_EN
  task automatic test_mispredict();
    bit ok;
    bus.pred_taken = 1'b1;
    drive(1'b1, 2'd0, BT_BGE, 4'hF, pack4(1, 1, 1, 1), pack4(5, 5, 5, 5), 32'h20, 32'h200);
    accept(ok);
    tick();
    checks++; if (bus.next_pc !== 32'h204) begin failures++; $display("FAIL mp_next_pc got=%h want=204", bus.next_pc); end
    checks++; if (bus.mispredict !== 1'b1) begin failures++; $display("FAIL mp_bge got=%h want=1", bus.mispredict); end
    drive(1'b1, 2'd0, BT_BEQ, 4'hF, pack4(4, 4, 4, 4), pack4(4, 4, 4, 4), 32'h20, 32'h200);
    accept(ok);
    tick();
    checks++; if (bus.mispredict !== 1'b0) begin failures++; $display("FAIL mp_correct got=%h want=0", bus.mispredict); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.mispredict !== 1'b0) begin
      failures++; $display("FAIL mp_idle got=%h/%h want=0/0", bus.out_valid, bus.mispredict);
    end
    bus.pred_taken = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.branch      = 1'b0;
    bus.j_type      = 2'd0;
    bus.branch_type = BT_BEQ;
    bus.lane_mask   = 4'h0;
    bus.reg_a       = '0;
    bus.reg_b       = '0;
    bus.imm         = '0;
    bus.current_pc  = '0;
`ifdef BRANCH_PRED_EN
    bus.pred_taken  = 1'b0;
`endif
    test_reset();
    test_beq();
    test_bltu();
    test_jalr();
    test_jump_precedence();
    test_lane_mask_zero();
    test_back_to_back();
    test_reset_in_flight();
`ifdef BRANCH_PRED_EN
    test_mispredict();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
